ceespu_wb_stage: RTL

Registered, parametrised writeback stage for the ceespu pipeline. It sits between the memory stage and the register file. Each cycle it selects among the ALU result, the sign/zero-extended sub-word load data, or the link address (PC<<2), and drives a registered register-file write port. Unlike the old purely combinational selector, it supports variable-latency data memory through a valid handshake with stall and timeout, handles 32- or 64-bit datapaths, and suppresses writes to r0.

---
 rtl/ceespu_pkg.sv | 22 ++
 rtl/ceespu_load_align.sv | 42 ++++
 rtl/ceespu_wb_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ceespu_pkg.sv
// Shared encodings for the ceespu writeback stage: writeback source select,
// load type codes and the writeback FSM state type.
package ceespu_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    localparam logic [2:0] MEM_W  = 3'd0;
    localparam logic [2:0] MEM_HS = 3'd1;
    localparam logic [2:0] MEM_BS = 3'd2;
    localparam logic [2:0] MEM_HU = 3'd3;
    localparam logic [2:0] MEM_BU = 3'd4;
    localparam logic [2:0] MEM_WS = 3'd5;
    localparam logic [2:0] MEM_WU = 3'd6;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/ceespu_load_align.sv
// Combinational load extractor: picks the addressed lane of a raw memory word
// and sign/zero-extends it to the datapath width.
module ceespu_load_align
    import ceespu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [2:0]        i_sel_mem,
    input  logic [LANE_W-1:0] i_off,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [LANE_W-1:0] w_lane_mask;
    logic [LANE_W-1:0] w_sh;
    logic [DATA_W-1:0] w_lane;

    // The mask drops the offset bits below the access size; on a 32-bit
    // datapath the 32-bit word codes collapse to a plain full-word read.
    always_comb begin
        case (i_sel_mem)
            MEM_BS, MEM_BU: w_lane_mask = {LANE_W{1'b1}};
            MEM_HS, MEM_HU: w_lane_mask = {LANE_W{1'b1}} << 1;
            MEM_WS, MEM_WU: w_lane_mask = {LANE_W{1'b1}} << 2;
            default:        w_lane_mask = '0;
        endcase
        w_sh   = i_off & w_lane_mask;
        w_lane = i_data >> {w_sh, 3'b000};

        case (i_sel_mem)
            MEM_HS:  o_data = DATA_W'($signed(w_lane[15:0]));
            MEM_BS:  o_data = DATA_W'($signed(w_lane[7:0]));
            MEM_HU:  o_data = DATA_W'(w_lane[15:0]);
            MEM_BU:  o_data = DATA_W'(w_lane[7:0]);
            MEM_WS:  o_data = DATA_W'($signed(w_lane[31:0]));
            MEM_WU:  o_data = DATA_W'(w_lane[31:0]);
            default: o_data = w_lane;
        endcase
    end

endmodule

// File: rtl/ceespu_wb_stage.sv
// Registered writeback stage with variable-latency load handshake and timeout.
// Optional CEESPU_WB_MISALIGN_TRAP_EN adds O_misaligned and suppresses misaligned loads.
//
// state    | meaning
// IDLE     | accept a new instruction; ALU/link/ready loads complete here
// WAIT_MEM | load pending on I_dmemValid; upstream stalled, timeout counting
module ceespu_wb_stage
    import ceespu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 14,
    parameter int RADDR_W     = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_valid,
    input  logic               I_regWrite,
    input  logic [RADDR_W-1:0] I_rd,
    input  logic [1:0]         I_selWb,
    input  logic [2:0]         I_selMem,
    input  logic [PC_W-1:0]    I_PC,
    input  logic [DATA_W-1:0]  I_aluResult,
    input  logic [DATA_W-1:0]  I_dmemData,
    input  logic               I_dmemValid,
    output logic               O_stall,
    output logic               O_writeEnable,
    output logic [RADDR_W-1:0] O_writeAddr,
    output logic [DATA_W-1:0]  O_writeData,
    output logic               O_busError
`ifdef CEESPU_WB_MISALIGN_TRAP_EN
    ,
    output logic               O_misaligned
`endif
);

    localparam int         LANE_W   = $clog2(DATA_W / 8);
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    wb_state_t          r_state;
    wb_state_t          w_state_nxt;
    logic [RADDR_W-1:0] r_rd;
    logic               r_reg_write;
    logic [2:0]         r_sel_mem;
    logic [LANE_W-1:0]  r_off;
    logic [7:0]         r_tmo_cnt;
    logic               r_we;
    logic [RADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_bus_err;

    logic               w_in_wait;
    logic               w_is_load;
    logic               w_rw;
    logic [RADDR_W-1:0] w_rd;
    logic [2:0]         w_sel_mem;
    logic [LANE_W-1:0]  w_off;
    logic [DATA_W-1:0]  w_load_data;
    logic [DATA_W-1:0]  w_link_data;
    logic [DATA_W-1:0]  w_result;
    logic               w_done;
    logic               w_capture;
    logic               w_timeout;
    logic               w_suppress;

    // While waiting, the captured fields drive the extractor instead of upstream.
    assign w_in_wait   = (r_state == WAIT_MEM);
    assign w_is_load   = w_in_wait || (I_selWb == WB_MEM);
    assign w_rd        = w_in_wait ? r_rd        : I_rd;
    assign w_rw        = w_in_wait ? r_reg_write : I_regWrite;
    assign w_sel_mem   = w_in_wait ? r_sel_mem   : I_selMem;
    assign w_off       = w_in_wait ? r_off       : I_aluResult[LANE_W-1:0];
    assign w_link_data = DATA_W'({I_PC, 2'b00});

    ceespu_load_align #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_load_align (
        .i_sel_mem (w_sel_mem),
        .i_off     (w_off),
        .i_data    (I_dmemData),
        .o_data    (w_load_data)
    );

    always_comb begin
        if (w_is_load)
            w_result = w_load_data;
        else if ((I_selWb & WB_LINK) != 2'b00)
            w_result = w_link_data;
        else
            w_result = I_aluResult;
    end

`ifdef CEESPU_WB_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misaligned;

    always_comb begin
        case (w_sel_mem)
            MEM_BS, MEM_BU: w_misaligned = 1'b0;
            MEM_HS, MEM_HU: w_misaligned = w_off[0];
            MEM_WS, MEM_WU: w_misaligned = (DATA_W == 64) ? (w_off[1:0] != 2'b00)
                                                          : (w_off != '0);
            default:        w_misaligned = (w_off != '0);
        endcase
    end

    assign w_suppress   = w_is_load && w_misaligned;
    assign O_misaligned = r_misaligned;

    always_ff @(posedge I_clk) begin
        if (!I_rst)
            r_misaligned <= 1'b0;
        else
            r_misaligned <= w_done && w_suppress;
    end
`else
    assign w_suppress = 1'b0;
`endif

    always_ff @(posedge I_clk) begin
        if (!I_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (I_valid) begin
                    if (w_is_load && !I_dmemValid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = WAIT_MEM;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // Data arriving on the last allowed cycle beats the timeout.
                if (I_dmemValid) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst) begin
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_sel_mem   <= '0;
            r_off       <= '0;
            r_tmo_cnt   <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_bus_err <= w_timeout;
            if (w_capture) begin
                r_rd        <= I_rd;
                r_reg_write <= I_regWrite;
                r_sel_mem   <= I_selMem;
                r_off       <= I_aluResult[LANE_W-1:0];
                r_tmo_cnt   <= '0;
            end else if (w_in_wait) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (w_done) begin
                r_we    <= w_rw && (w_rd != '0) && !w_suppress;
                r_waddr <= w_rd;
                r_wdata <= w_result;
            end
        end
    end

    assign O_stall       = w_in_wait;
    assign O_writeEnable = r_we;
    assign O_writeAddr   = r_waddr;
    assign O_writeData   = r_wdata;
    assign O_busError    = r_bus_err;

endmodule
